disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit common-anode 7-segment display sharing one combinational hex decoder.
- Each slot drives one digit's nibble to the shared decoder, takes the decoded active-low segments back, gates them and enables one digit anode.
- Display contents load through a ready/load handshake. New data is applied only at frame boundaries, so no frame ever shows a mix of old and new data.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, Clk cycles per digit slot (>=2).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Load  in  1  request to load new display contents; sampled only when Ready=1.
- Data  in  4*NUM_DIGITS  digit values; Data[3:0] is digit 0 (rightmost, least significant).
- BlankMask  in  NUM_DIGITS  1 = force that digit dark; captured with Data.
- LzbEn  in  1  leading-zero blanking enable; captured with Data.
- Ready  out  1  1 = pending buffer free, Load accepted.
- Nibble  out  4  value of the current digit, to the shared decoder input.
- SegIn  in  7  active-low segments from the shared decoder (combinational from Nibble).
- Seg  out  7  active-low segments to the display pins.
- DigitSel  out  NUM_DIGITS  active-low anode enables, at most one low.
- FrameTick  out  1  one-cycle pulse at each frame wrap.

Behaviour:
Reset (asynchronous, all at once):
- Prescaler=0, index=0.
- Active Data=0, active BlankMask=all ones (display dark), active LzbEn=0, pending buffer empty.
- Outputs: Ready=1, Nibble=0, DigitSel=all ones, Seg=7'h7F, FrameTick=0.
- Reset asserted mid-frame or mid-handshake discards any pending load.

Prescaler and digit index:
- Prescaler counts 0..REFRESH_DIV-1 and wraps.
- slot_end = prescaler==REFRESH_DIV-1.
- On slot_end, index increments; it wraps NUM_DIGITS-1 -> 0.
- frame_end = slot_end && index==NUM_DIGITS-1.
- FrameTick is registered: high for exactly the first cycle of index 0 after a wrap.

Outputs per slot (all registered, updating on the same edge):
- Nibble = active Data[4*index+3 : 4*index].
- DigitSel[index]=0, but only when prescaler!=0 and the digit is not blanked. Prescaler==0 is a one-cycle all-off guard slot against ghosting.
- All other DigitSel bits =1.
- Digit blanked = active BlankMask[index] OR LZB(index).

Leading-zero blanking (LZB):
- LZB(i)=1 iff active LzbEn=1, i!=0, and active digits i..NUM_DIGITS-1 are all zero.
- Digit 0 is never LZB-blanked.

Seg gating:
- Seg = SegIn when some DigitSel bit is low, else 7'h7F.
- Seg is combinational from SegIn and registered state; latency from Nibble to Seg equals the decoder's combinational delay.

Load handshake:
- On Load && Ready at a clock edge: capture Data, BlankMask and LzbEn into the pending buffer; Ready=0 from the next cycle.
- Load while Ready=0 is ignored; the pending buffer is unchanged.
- At the first frame_end with pending valid: pending is copied to active (visible from index 0 of the next frame); Ready=1 from the same edge.
- Load && Ready on the same edge as frame_end: capture to pending only; it commits at the following frame_end. No bypass path.
- Commit latency: at most NUM_DIGITS*REFRESH_DIV cycles after acceptance.

Width rules:
- Prescaler width is clog2(REFRESH_DIV); index width is clog2(NUM_DIGITS), minimum 1.
- No arithmetic on Data.

Test Plan:
(NUM_DIGITS=4, REFRESH_DIV=4; an ideal hex decoder model drives SegIn.)
1. Reset release -> Ready=1, Seg=7'h7F and DigitSel=4'b1111 for a full frame (BlankMask reset to all ones); FrameTick pulses every 16 cycles.
2. Load Data=16'h12AF, BlankMask=0, LzbEn=0 -> Ready=0 next cycle; after the next frame_end, slot0 shows Nibble=F with DigitSel=1110, slot1 Nibble=A/1101, slot2 2/1011, slot3 1/0111; DigitSel=1111 on each slot's first cycle; Ready returns to 1 at the commit edge.
3. Load 16'h0005 with LzbEn=1 -> only digit 0 is lit (Seg=~7'b1101101); digits 1-3 stay dark.
   Load 16'h0000 with LzbEn=1 -> digit 0 shows 0 (Seg=~7'b0111111).
4. Second Load while Ready=0 with different Data -> ignored; the first Data is displayed.
   Load coincident with frame_end -> visible only after the next frame_end.
5. Load BlankMask=4'b0100, Data=16'h8888 -> digit 2 never enabled; the others show Seg=~7'b1111111.
6. Assert Reset mid-slot with a load pending -> all outputs return to reset values immediately (asynchronously); the pending data never appears after release.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a frame-synchronous double-buffered load.
// Latency: Nibble/DigitSel/FrameTick registered; Seg combinational from SegIn. Load commits at the next frame wrap.
// Backpressure: o_ready drops while a load is pending; loads while o_ready=0 are ignored.
module disp_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_blank_mask,
    input  logic                    i_lzb_en,
    output logic                    o_ready,
    output logic [3:0]              o_nibble,
    input  logic [6:0]              i_seg_in,
    output logic [6:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_digit_sel,
    output logic                    o_frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_index;
    logic [DW-1:0]         r_act_data;
    logic [NUM_DIGITS-1:0] r_act_mask;
    logic                  r_act_lzb;
    logic [DW-1:0]         r_pend_data;
    logic [NUM_DIGITS-1:0] r_pend_mask;
    logic                  r_pend_lzb;
    logic                  r_pend_vld;
    logic [3:0]            r_nibble;
    logic [NUM_DIGITS-1:0] r_digit_sel;
    logic                  r_frame_tick;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_commit;
    logic                  w_accept;
    logic [PW-1:0]         w_presc_nxt;
    logic [IW-1:0]         w_index_nxt;
    logic [DW-1:0]         w_act_data_nxt;
    logic [NUM_DIGITS-1:0] w_act_mask_nxt;
    logic                  w_act_lzb_nxt;
    logic [NUM_DIGITS-1:0] w_lzb;
    logic                  w_zero_run;
    logic [3:0]            w_nibble_nxt;
    logic [NUM_DIGITS-1:0] w_sel_nxt;

    always_comb begin
        w_slot_end     = (r_presc == PRESC_LAST);
        w_frame_end    = w_slot_end && (r_index == IDX_LAST);
        w_commit       = w_frame_end && r_pend_vld;
        w_accept       = i_load && !r_pend_vld;
        w_presc_nxt    = w_slot_end ? '0 : r_presc + PW'(1);
        w_index_nxt    = r_index;
        if (w_slot_end) begin
            w_index_nxt = (r_index == IDX_LAST) ? '0 : r_index + IW'(1);
        end
        w_act_data_nxt = w_commit ? r_pend_data : r_act_data;
        w_act_mask_nxt = w_commit ? r_pend_mask : r_act_mask;
        w_act_lzb_nxt  = w_commit ? r_pend_lzb  : r_act_lzb;
    end

    // Outputs are derived from next-state values so they line up with the slot they describe,
    // including the first slot of a frame that has just committed new contents.
    always_comb begin
        w_zero_run   = 1'b1;
        w_lzb        = '0;
        w_nibble_nxt = 4'h0;
        w_sel_nxt    = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (w_act_data_nxt[4*i +: 4] == 4'h0);
            if (i != 0) begin
                w_lzb[i] = w_act_lzb_nxt && w_zero_run;
            end
            if (w_index_nxt == IW'(i)) begin
                w_nibble_nxt = w_act_data_nxt[4*i +: 4];
                if ((w_presc_nxt != '0) && !(w_act_mask_nxt[i] || w_lzb[i])) begin
                    w_sel_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_presc      <= '0;
            r_index      <= '0;
            r_act_data   <= '0;
            r_act_mask   <= '1;
            r_act_lzb    <= 1'b0;
            r_pend_data  <= '0;
            r_pend_mask  <= '1;
            r_pend_lzb   <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_nibble     <= 4'h0;
            r_digit_sel  <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_presc      <= w_presc_nxt;
            r_index      <= w_index_nxt;
            r_act_data   <= w_act_data_nxt;
            r_act_mask   <= w_act_mask_nxt;
            r_act_lzb    <= w_act_lzb_nxt;
            r_nibble     <= w_nibble_nxt;
            r_digit_sel  <= w_sel_nxt;
            r_frame_tick <= w_frame_end;
            // Accept and commit are mutually exclusive: accept needs an empty buffer.
            if (w_accept) begin
                r_pend_data <= i_data;
                r_pend_mask <= i_blank_mask;
                r_pend_lzb  <= i_lzb_en;
                r_pend_vld  <= 1'b1;
            end else if (w_commit) begin
                r_pend_vld  <= 1'b0;
            end
        end
    end

    assign o_ready      = !r_pend_vld;
    assign o_nibble     = r_nibble;
    assign o_digit_sel  = r_digit_sel;
    assign o_frame_tick = r_frame_tick;
    assign o_seg        = (&r_digit_sel) ? 7'h7F : i_seg_in;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl (4 digits, 4 cycles per slot) with an ideal hex decoder on SegIn.
module tb_disp_scan_ctrl;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        load  = 1'b0;
    logic [15:0] data  = 16'h0;
    logic [3:0]  mask  = 4'h0;
    logic        lzb   = 1'b0;
    logic        ready;
    logic [3:0]  nibble;
    logic [6:0]  seg_in;
    logic [6:0]  seg;
    logic [3:0]  sel;
    logic        tick;

    int checks = 0;
    int errors = 0;

    disp_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_load(load), .i_data(data),
        .i_blank_mask(mask), .i_lzb_en(lzb), .o_ready(ready), .o_nibble(nibble),
        .i_seg_in(seg_in), .o_seg(seg), .o_digit_sel(sel), .o_frame_tick(tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    assign seg_in = ~hex7(nibble);

    // Model: a cycle count since reset fixes slot and digit; buffers hold what has been loaded.
    int          m_cyc  = 0;
    logic [15:0] m_data = 16'h0;
    logic [3:0]  m_mask = 4'hF;
    logic        m_lzb  = 1'b0;
    logic        m_pend = 1'b0;
    logic [15:0] p_data = 16'h0;
    logic [3:0]  p_mask = 4'hF;
    logic        p_lzb  = 1'b0;
    logic        m_tick = 1'b0;
    bit          m_fe;
    bit          m_rdy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_data = 16'h0; m_mask = 4'hF; m_lzb = 1'b0;
            m_pend = 1'b0; m_tick = 1'b0;
        end else begin
            m_fe  = (m_cyc % 16) == 15;
            m_rdy = !m_pend;
            if (m_fe && m_pend) begin
                m_data = p_data; m_mask = p_mask; m_lzb = p_lzb; m_pend = 1'b0;
            end
            if (load && m_rdy) begin
                p_data = data; p_mask = mask; p_lzb = lzb; m_pend = 1'b1;
            end
            m_tick = m_fe;
            m_cyc++;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int          ph;
        int          idx;
        logic        lz;
        logic        lit;
        logic [3:0]  e_nib;
        logic [3:0]  e_sel;
        ph    = m_cyc % 4;
        idx   = (m_cyc / 4) % 4;
        e_nib = m_data[4*idx +: 4];
        lz    = m_lzb && (idx != 0) && ((m_data >> (4*idx)) == 16'h0);
        lit   = (ph != 0) && !(m_mask[idx] || lz);
        e_sel = lit ? ~(4'b0001 << idx) : 4'hF;
        chk("nibble", {12'h0, nibble}, {12'h0, e_nib});
        chk("digit_sel", {12'h0, sel}, {12'h0, e_sel});
        chk("seg", {9'h0, seg}, {9'h0, (lit ? ~hex7(e_nib) : 7'h7F)});
        chk("ready", {15'h0, ready}, {15'h0, !m_pend});
        chk("frame_tick", {15'h0, tick}, {15'h0, m_tick});
    end

    // Advance at least one cycle, then stop at the negedge whose frame phase is ph.
    task automatic goto(input int ph);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((m_cyc % 16) != ph && n < 40);
        chk("goto_phase", 16'(m_cyc % 16), 16'(ph));
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m, input logic z);
        @(posedge clk);
        #1 load = 1'b1; data = d; mask = m; lzb = z;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Dark after reset, frame tick every 16 cycles
        @(negedge clk);
        chk("rst_ready", {15'h0, ready}, 16'h1);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_sel", {12'h0, sel}, 16'h000F);
        goto(0);
        chk("tick_at_wrap", {15'h0, tick}, 16'h1);
        goto(1);
        chk("tick_one_cycle", {15'h0, tick}, 16'h0);
        goto(6);
        chk("dark_frame_sel", {12'h0, sel}, 16'h000F);

        // Basic load and per-slot scan
        do_load(16'h12AF, 4'h0, 1'b0);
        @(negedge clk);
        chk("ready_drop", {15'h0, ready}, 16'h0);
        goto(15);
        goto(0);
        chk("commit_ready", {15'h0, ready}, 16'h1);
        chk("guard_sel", {12'h0, sel}, 16'h000F);
        chk("slot0_nib", {12'h0, nibble}, 16'h000F);
        goto(1);
        chk("slot0_sel", {12'h0, sel}, 16'h000E);
        chk("slot0_seg", {9'h0, seg}, 16'h000E);
        goto(5);
        chk("slot1", {8'h0, nibble, sel}, 16'h00AD);
        goto(9);
        chk("slot2", {8'h0, nibble, sel}, 16'h002B);
        goto(13);
        chk("slot3", {8'h0, nibble, sel}, 16'h0017);

        // Leading-zero blanking
        do_load(16'h0005, 4'h0, 1'b1);
        goto(15);
        goto(5);
        chk("lzb_dig1_sel", {12'h0, sel}, 16'h000F);
        chk("lzb_dig1_seg", {9'h0, seg}, 16'h007F);
        goto(1);
        chk("lzb_dig0_seg", {9'h0, seg}, 16'h0012);
        do_load(16'h0000, 4'h0, 1'b1);
        goto(15);
        goto(1);
        chk("lzb_zero_seg", {9'h0, seg}, 16'h0040);
        chk("lzb_zero_sel", {12'h0, sel}, 16'h000E);

        // Load while busy is dropped; load on the frame-end edge waits a frame
        do_load(16'h1234, 4'h0, 1'b0);
        do_load(16'hBEEF, 4'h0, 1'b0);
        goto(15);
        goto(1);
        chk("ignored_d0", {12'h0, nibble}, 16'h0004);
        goto(13);
        chk("ignored_d3", {12'h0, nibble}, 16'h0001);
        goto(14);
        do_load(16'h5678, 4'h0, 1'b0);
        @(negedge clk);
        chk("coinc_old", {12'h0, nibble}, 16'h0004);
        chk("coinc_ready", {15'h0, ready}, 16'h0);
        goto(15);
        goto(1);
        chk("coinc_new", {12'h0, nibble}, 16'h0008);

        // Masked digit
        do_load(16'h8888, 4'b0100, 1'b0);
        goto(15);
        goto(9);
        chk("mask_sel", {12'h0, sel}, 16'h000F);
        chk("mask_seg", {9'h0, seg}, 16'h007F);
        goto(13);
        chk("mask_d3_sel", {12'h0, sel}, 16'h0007);
        chk("mask_d3_seg", {9'h0, seg}, 16'h0000);

        // Asynchronous reset with a pending load
        goto(1);
        do_load(16'hCAFE, 4'h0, 1'b0);
        goto(13);
        chk("pre_rst_ready", {15'h0, ready}, 16'h0);
        #1 rst = 1'b1;
        #1;
        chk("arst_sel", {12'h0, sel}, 16'h000F);
        chk("arst_seg", {9'h0, seg}, 16'h007F);
        chk("arst_ready", {15'h0, ready}, 16'h1);
        chk("arst_nib", {12'h0, nibble}, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_rst_sel", {12'h0, sel}, 16'h000F);
        chk("post_rst_nib", {12'h0, nibble}, 16'h0000);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
